theta_accumulator_mc: RTL and testbench

Multi-channel, parametrised successor of the single-channel angle accumulator. It keeps CHANNELS independent angle registers in microradians. On each start it adds a signed delta to the selected channel, then iteratively normalises the result into a configurable one-turn window. It sits between the gyro/odometry integration datapath and the heading consumers, and reports completion with a one-cycle done pulse and an error flag.

---
 rtl/theta_accumulator_mc.sv | 191 +++++++++++++++++++
 tb/tb_theta_accumulator_mc.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/theta_accumulator_mc.sv
// Multi-channel angle accumulator (microradians).
// Keeps CHANNELS independent signed angle registers. On start, adds delta_theta to the selected
// channel, then walks the sum back into a one-turn window one TWO_PI correction per cycle.
// Reports completion with a one-cycle done pulse and an error flag.
//
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous active-low reset
//   start          accumulate request, sampled only when idle
//   clear          zero the selected channel, sampled only when idle, beats start
//   channel        target channel; out-of-range values are ignored
//   delta_theta    signed increment, needed only in the start cycle
//   theta          last normalised result, held until the next done
//   theta_channel  channel that theta belongs to
//   busy           high whenever not idle
//   done           one-cycle completion pulse
//   error          normalisation ran out of corrections; held until the next accepted start
module theta_accumulator_mc #(
  parameter int unsigned     WIDTH        = 64,
  parameter int unsigned     CHANNELS     = 4,
  parameter longint unsigned TWO_PI       = 64'd6283185,
  parameter bit              SIGNED_RANGE = 1'b1,
  parameter int unsigned     MAX_ITER     = 16,
  localparam int unsigned    ChanW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    clear,
  input  logic [ChanW-1:0]        channel,
  input  logic signed [WIDTH-1:0] delta_theta,
  output logic signed [WIDTH-1:0] theta,
  output logic [ChanW-1:0]        theta_channel,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);

  localparam int unsigned IterW = $clog2(MAX_ITER + 1);

  // One extra bit of headroom so reg + delta can never wrap.
  localparam logic signed [WIDTH:0] TwoPi = (WIDTH + 1)'(TWO_PI);
  localparam logic signed [WIDTH:0] HalfPi = (WIDTH + 1)'(TWO_PI / 2);
  localparam logic signed [WIDTH:0] Lo = SIGNED_RANGE ? -HalfPi : '0;
  localparam logic signed [WIDTH:0] Hi = Lo + TwoPi;

  typedef enum logic [1:0] {StIdle, StSoma, StNormaliza, StDone} state_e;

  state_e state_q, state_d;

  logic [ChanW-1:0]        ch_q, ch_d;
  logic signed [WIDTH-1:0] delta_q, delta_d;
  logic signed [WIDTH:0]   acc_q, acc_d;
  logic [IterW-1:0]        iter_q, iter_d;
  logic signed [WIDTH-1:0] chan_q [CHANNELS];
  logic signed [WIDTH-1:0] chan_d [CHANNELS];
  logic signed [WIDTH-1:0] theta_q, theta_d;
  logic [ChanW-1:0]        theta_ch_q, theta_ch_d;
  logic                    error_q, error_d;

  logic chan_ok;
  logic above;
  logic below;
  logic in_win;
  logic iter_max;

  assign chan_ok  = 32'(channel) < 32'(CHANNELS);
  assign above    = acc_q >= Hi;
  assign below    = acc_q < Lo;
  assign in_win   = !above && !below;
  assign iter_max = iter_q == IterW'(MAX_ITER);

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (chan_ok && !clear && start) begin
          state_d = StSoma;
        end
      end
      StSoma:      state_d = StNormaliza;
      StNormaliza: begin
        if (in_win || iter_max) begin
          state_d = StDone;
        end
      end
      StDone:      state_d = StIdle;
      default:     state_d = StIdle;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      StIdle:  busy = 1'b0;
      StDone: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: busy = 1'b1;
    endcase
  end

  // Datapath next-state
  always_comb begin
    ch_d       = ch_q;
    delta_d    = delta_q;
    acc_d      = acc_q;
    iter_d     = iter_q;
    chan_d     = chan_q;
    theta_d    = theta_q;
    theta_ch_d = theta_ch_q;
    error_d    = error_q;
    unique case (state_q)
      StIdle: begin
        if (chan_ok) begin
          if (clear) begin
            chan_d[channel] = '0;
          end else if (start) begin
            ch_d    = channel;
            delta_d = delta_theta;
            error_d = 1'b0;
          end
        end
      end
      StSoma: begin
        acc_d  = (WIDTH + 1)'(chan_q[ch_q]) + (WIDTH + 1)'(delta_q);
        iter_d = '0;
      end
      StNormaliza: begin
        if (in_win) begin
          chan_d[ch_q] = acc_q[WIDTH-1:0];
          theta_d      = acc_q[WIDTH-1:0];
          theta_ch_d   = ch_q;
        end else if (iter_max) begin
          // Give up: the stored angle and the reported theta keep their old values.
          error_d = 1'b1;
        end else if (above) begin
          acc_d  = acc_q - TwoPi;
          iter_d = iter_q + IterW'(1);
        end else begin
          acc_d  = acc_q + TwoPi;
          iter_d = iter_q + IterW'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      ch_q       <= '0;
      delta_q    <= '0;
      acc_q      <= '0;
      iter_q     <= '0;
      theta_q    <= '0;
      theta_ch_q <= '0;
      error_q    <= 1'b0;
      for (int i = 0; i < int'(CHANNELS); i++) begin
        chan_q[i] <= '0;
      end
    end else begin
      ch_q       <= ch_d;
      delta_q    <= delta_d;
      acc_q      <= acc_d;
      iter_q     <= iter_d;
      theta_q    <= theta_d;
      theta_ch_q <= theta_ch_d;
      error_q    <= error_d;
      chan_q     <= chan_d;
    end
  end

  assign theta         = theta_q;
  assign theta_channel = theta_ch_q;
  assign error         = error_q;

endmodule

// File: tb/tb_theta_accumulator_mc.sv
// Scoreboard bench: two instances (signed window and [0, TWO_PI) window) share one stimulus
// stream. Expected results come from a turn-counting reference model and are checked by a
// separate monitor whenever done pulses.
module tb_theta_accumulator_mc;

  localparam int     CH      = 4;
  localparam int     MAXITER = 16;
  localparam longint TP      = 6283185;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               start = 1'b0;
  logic               clear = 1'b0;
  logic [1:0]         channel = '0;
  logic signed [63:0] delta_theta = '0;

  logic signed [63:0] theta_s, theta_u;
  logic [1:0]         thch_s, thch_u;
  logic               busy_s, busy_u, done_s, done_u, err_s, err_u;

  always #5 clk = ~clk;

  theta_accumulator_mc #(.SIGNED_RANGE(1'b1)) dut_s (
    .clk(clk), .reset(reset), .start(start), .clear(clear), .channel(channel),
    .delta_theta(delta_theta), .theta(theta_s), .theta_channel(thch_s),
    .busy(busy_s), .done(done_s), .error(err_s)
  );

  theta_accumulator_mc #(.SIGNED_RANGE(1'b0)) dut_u (
    .clk(clk), .reset(reset), .start(start), .clear(clear), .channel(channel),
    .delta_theta(delta_theta), .theta(theta_u), .theta_channel(thch_u),
    .busy(busy_u), .done(done_u), .error(err_u)
  );

  typedef struct {
    longint theta;
    int     ch;
    bit     err;
    int     cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference model state; index 0 = signed window, 1 = [0, TWO_PI)
  longint mreg [2][CH];
  longint mtheta [2];
  int     mch [2];
  bit     merr [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < CH; c++) mreg[d][c] = 0;
      mtheta[d] = 0;
      mch[d] = 0;
      merr[d] = 0;
    end
  endfunction

  // Count whole turns needed to reach the window instead of stepping one at a time.
  function automatic exp_t model_start(int d, int c, longint delta, int s);
    exp_t   e;
    longint lo, hi, v, k;
    lo = (d == 0) ? -(TP / 2) : 0;
    hi = lo + TP;
    v  = mreg[d][c] + delta;
    if (v >= hi)     k = (v - hi) / TP + 1;
    else if (v < lo) k = (lo - v + TP - 1) / TP;
    else             k = 0;
    merr[d] = 0;
    if (k > MAXITER) begin
      merr[d] = 1;
      k = MAXITER;
    end else begin
      v = (v >= hi) ? v - k * TP : v + k * TP;
      mreg[d][c] = v;
      mtheta[d] = v;
      mch[d] = c;
    end
    e.theta = mtheta[d];
    e.ch    = mch[d];
    e.err   = merr[d];
    // Start cycle is cycle 0; done lands in cycle 3+k, i.e. 2+k edges after the sampling edge.
    e.cyc   = s + 2 + int'(k);
    return e;
  endfunction

  // Monitor
  always @(negedge clk) begin
    if (reset) begin
      if (done_s) begin
        if (q0.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL signed spurious done at cycle %0d", cyc);
        end else begin
          exp_t e;
          e = q0.pop_front();
          chk("signed theta", theta_s, e.theta);
          chk("signed theta_channel", thch_s, e.ch);
          chk("signed error", err_s, e.err);
          chk("signed done cycle", cyc, e.cyc);
        end
      end
      if (done_u) begin
        if (q1.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unsigned spurious done at cycle %0d", cyc);
        end else begin
          exp_t e;
          e = q1.pop_front();
          chk("unsigned theta", theta_u, e.theta);
          chk("unsigned theta_channel", thch_u, e.ch);
          chk("unsigned error", err_u, e.err);
          chk("unsigned done cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((busy_s || busy_u) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy_s || busy_u) begin
      checks++;
      errors++;
      $display("FAIL idle timeout: busy_s=%0b busy_u=%0b", busy_s, busy_u);
    end
  endtask

  // Called at a negedge with both instances idle; returns at the negedge after the sampling edge.
  task automatic do_start(input int c, input longint delta);
    channel     = 2'(c);
    delta_theta = delta;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    q0.push_back(model_start(0, c, delta, cyc));
    q1.push_back(model_start(1, c, delta, cyc));
  endtask

  task automatic do_clear(input int c, input bit with_start);
    channel     = 2'(c);
    delta_theta = 64'sd777;
    clear       = 1'b1;
    start       = with_start;
    @(negedge clk);
    clear = 1'b0;
    start = 1'b0;
    mreg[0][c] = 0;
    mreg[1][c] = 0;
  endtask

  task automatic go(input int c, input longint delta);
    wait_idle();
    do_start(c, delta);
    wait_idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset theta_s", theta_s, 0);
    chk("reset theta_u", theta_u, 0);
    chk("reset thch_s", thch_s, 0);
    chk("reset busy_s", busy_s, 0);
    chk("reset done_s", done_s, 0);
    chk("reset error_s", err_s, 0);
    chk("reset busy_u", busy_u, 0);
    chk("reset done_u", done_u, 0);
    reset = 1'b1;
    @(negedge clk);

    // Basic accumulation, wrap and channel independence
    go(0, 1000000);
    go(0, 3000000);
    go(1, -5000000);
    go(0, 0);

    // Iteration limit boundary
    do_clear(2, 1'b0);
    go(2, 16 * TP + 5);
    go(2, 17 * TP);
    go(2, 0);

    // clear beats start: no done, channel zeroed
    go(0, 0);
    do_clear(0, 1'b1);
    repeat (6) @(negedge clk);
    go(0, 0);

    // start/clear while busy are dropped
    wait_idle();
    do_clear(1, 1'b0);
    go(1, 42);
    do_start(1, 10 * TP);
    channel = 2'd3; delta_theta = 64'sd123; start = 1'b1;
    @(negedge clk);
    channel = 2'd1; start = 1'b0; clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    wait_idle();
    go(3, 0);
    go(1, 0);

    // Reset mid-normalisation aborts without write-back
    do_start(0, 12 * TP);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("abort busy_s", busy_s, 0);
    chk("abort done_s", done_s, 0);
    chk("abort busy_u", busy_u, 0);
    chk("abort error_s", err_s, 0);
    chk("abort theta_s", theta_s, 0);
    q0.delete();
    q1.delete();
    model_reset();
    reset = 1'b1;
    @(negedge clk);
    for (int c = 0; c < CH; c++) go(c, 0);

    // Window edges
    do_clear(3, 1'b0);
    go(3, -1);
    do_clear(3, 1'b0);
    go(3, TP);
    go(3, TP / 2 + 1);
    go(3, -TP);

    // Randomised traffic
    for (int i = 0; i < 150; i++) begin
      int     c;
      longint d;
      c = int'($urandom_range(0, CH - 1));
      if ($urandom_range(0, 9) == 0) begin
        wait_idle();
        do_clear(c, 1'($urandom_range(0, 1)));
      end else begin
        if ($urandom_range(0, 1) == 0) d = longint'($urandom_range(0, 2 * TP)) - TP;
        else d = longint'($urandom_range(0, 40 * TP)) - 20 * TP;
        go(c, d);
      end
    end

    wait_idle();
    repeat (4) @(negedge clk);
    chk("signed scoreboard drained", q0.size(), 0);
    chk("unsigned scoreboard drained", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
